bus_dev_fifo: RTL and testbench
===============================

# bus_dev_fifo

Per-device endpoint buffer between a device agent/driver and the `bs_gnrt` bus generator, one instance per device (`drvrs` instances). A TX FIFO holds packets the device sends: they are presented to the bus on `pndng`/`D_pop` and removed on `pop`. An RX FIFO captures packets the bus delivers on `push`/`D_push`, keeping only those addressed to this device or to `broadcast`, for the monitor to drain.

## Interface
- `pckg_sz`, default 16: packet width. Bits `[pckg_sz-1:pckg_sz-8]` are the destination ID; the rest is payload.
- `depth`, default 8: entries per FIFO, power of two, ≥2.
- `broadcast`, default 8'hFF: destination ID accepted by every device.
- `id`, default 0: this device's 8-bit ID.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  driver write request into the TX FIFO.
- `wr_data`  in  pckg_sz  packet to enqueue.
- `full`  out  1  TX FIFO holds `depth` entries.
- `pndng`  out  1  TX FIFO not empty; goes to the bus.
- `D_pop`  out  pckg_sz  TX head (show-ahead); goes to the bus.
- `pop`  in  1  bus consumes the TX head.
- `push`  in  1  bus delivers a packet.
- `D_push`  in  pckg_sz  delivered packet.
- `rx_pop`  in  1  monitor consumes the RX head.
- `rx_empty`  out  1  RX FIFO empty.
- `rx_data`  out  pckg_sz  RX head (show-ahead).
- `rx_ovf`  out  1  sticky: an accepted packet was dropped because the RX FIFO was full.
- `pop_err`  out  1  sticky: `pop` was asserted while `pndng` was 0.
- `misaddr_cnt`  out  8  saturating count of packets dropped for wrong destination.

## Operation
- Reset (async assert, sync-safe release): both FIFOs empty, pointers 0. Outputs: `pndng`=0, `full`=0, `D_pop`=0, `rx_empty`=1, `rx_data`=0, `rx_ovf`=0, `pop_err`=0, `misaddr_cnt`=0.
- Each FIFO uses circular memory, `log2(depth)`-bit read/write pointers that wrap from `depth-1` to 0, and a `log2(depth)+1`-bit occupancy count.
- TX write: when `wr_en && !full`, store `wr_data` at the write pointer and advance it. When `wr_en && full`, drop the write silently; the stored state is unchanged.
- TX read: when `pop && pndng`, advance the read pointer. When `pop && !pndng`, no state change except `pop_err` ← 1.
- Same-cycle TX write and pop:
  - Not full and not empty: both happen and the count is unchanged.
  - Full: the pop happens and the write is rejected, because `full` is sampled before the edge.
  - Empty: the write happens, the pop is ignored, and `pop_err` is set.
- RX filter, when `push`=1: `dst = D_push[pckg_sz-1 -: 8]`.
  - If `dst==id || dst==broadcast`, the packet is accepted.
  - Otherwise it is dropped and `misaddr_cnt` increments, saturating at 255.
- RX accepted packet:
  - RX not full: store it.
  - RX full and `rx_pop`=0: drop it and set `rx_ovf`.
  - RX full and `rx_pop`=1 in the same cycle: the read frees the slot and the packet is stored.
- RX read: when `rx_pop && !rx_empty`, advance the read pointer. When `rx_pop && rx_empty`, ignore it.
- `D_pop` and `rx_data` are driven as 0 whenever their FIFO is empty.
- Sticky flags and `misaddr_cnt` clear only on `reset`.

## Timing
- Write→visible latency is 1 cycle: data written at edge N appears on `pndng`/`D_pop` (or `rx_empty`/`rx_data`) right after edge N.
- `full`, `pndng` and `rx_empty` are decoded from registered counts, with no combinational path from `wr_en`/`pop`/`push`/`rx_pop`.
- `D_pop` and `rx_data` are the memory word at the read pointer. After a pop at edge N, the next entry is presented right after edge N.
- Throughput is one write plus one read per FIFO per cycle.
- Reset asserted mid-transfer takes effect immediately, with no clock required. All in-flight and stored packets are lost.

## Test plan
- Reset, then 3 writes (16'h0111, 16'h0222, 16'h0333) with `pop` held low → `pndng`=1 and `D_pop`=16'h0111. Then 3 pops on consecutive cycles → `D_pop` shows 16'h0222, 16'h0333, then 0, and `pndng`=0.
- Write 9 packets with `depth`=8 and no pops → `full`=1 after the 8th write; the 9th is dropped. 8 pops return packets 1–8 in order, exercising pointer wrap.
- `full`=1 with `wr_en` and `pop` both asserted → count stays 7 next cycle and the new data is not stored. Then `pop` while empty → `pop_err`=1, and it stays set.
- `id`=2: push 16'h02AB, 16'hFFCD and 16'h03EF → RX holds 16'h02AB then 16'hFFCD, and `misaddr_cnt`=1.
- Fill RX with 8 packets, then push a 9th with `rx_pop`=0 → `rx_ovf`=1 and the packet is dropped. Push a 10th together with `rx_pop`=1 → it is stored and the count stays 8.
- Assert `reset` asynchronously mid-cycle with both FIFOs partly full → all outputs return to their reset values before the next clock edge.

Source files
------------

// File: rtl/bus_dev_fifo.sv
// Per-device endpoint buffer: a TX FIFO presented to the bus generator and an
// address-filtered RX FIFO drained by the monitor.
module bus_dev_fifo #(
    parameter int         pckg_sz   = 16,
    parameter int         depth     = 8,
    parameter logic [7:0] broadcast = 8'hFF,
    parameter logic [7:0] id        = 8'd0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [pckg_sz-1:0] wr_data,
    output logic               full,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               rx_pop,
    output logic               rx_empty,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_ovf,
    output logic               pop_err,
    output logic [7:0]         misaddr_cnt
);

    localparam int             aw       = $clog2(depth);
    localparam logic [aw:0]    full_cnt = (aw+1)'(depth);
    localparam logic [aw:0]    cnt_one  = (aw+1)'(1);
    localparam logic [aw-1:0]  ptr_one  = aw'(1);

    logic [pckg_sz-1:0] tx_mem [depth];
    logic [aw-1:0]      tx_wr_ptr, tx_rd_ptr;
    logic [aw:0]        tx_cnt;
    logic               tx_wr, tx_rd;

    logic [pckg_sz-1:0] rx_mem [depth];
    logic [aw-1:0]      rx_wr_ptr, rx_rd_ptr;
    logic [aw:0]        rx_cnt;
    logic               rx_full, rx_wr, rx_rd;
    logic [7:0]         dst;
    logic               addr_hit;

    // Status comes only from registered counts, so no request-to-flag path exists.
    assign full     = (tx_cnt == full_cnt);
    assign pndng    = (tx_cnt != '0);
    assign rx_full  = (rx_cnt == full_cnt);
    assign rx_empty = (rx_cnt == '0);

    assign tx_wr = wr_en && !full;
    assign tx_rd = pop && pndng;

    assign dst      = D_push[pckg_sz-1 -: 8];
    assign addr_hit = (dst == id) || (dst == broadcast);
    assign rx_rd    = rx_pop && !rx_empty;
    // A same-cycle read frees the slot a full RX FIFO needs for the new packet.
    assign rx_wr    = push && addr_hit && (!rx_full || rx_rd);

    assign D_pop   = pndng    ? tx_mem[tx_rd_ptr] : '0;
    assign rx_data = rx_empty ? '0 : rx_mem[rx_rd_ptr];

    // NOTE: storage arrays carry no reset; the empty-gated outputs hide stale words.
    always_ff @(posedge clk) begin
        if (tx_wr) tx_mem[tx_wr_ptr] <= wr_data;
        if (rx_wr) rx_mem[rx_wr_ptr] <= D_push;
    end

    // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
            pop_err   <= 1'b0;
        end else begin
            if (tx_wr) tx_wr_ptr <= tx_wr_ptr + ptr_one;
            if (tx_rd) tx_rd_ptr <= tx_rd_ptr + ptr_one;
            case ({tx_wr, tx_rd})
                2'b10:   tx_cnt <= tx_cnt + cnt_one;
                2'b01:   tx_cnt <= tx_cnt - cnt_one;
                default: tx_cnt <= tx_cnt;
            endcase
            if (pop && !pndng) pop_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wr_ptr   <= '0;
            rx_rd_ptr   <= '0;
            rx_cnt      <= '0;
            rx_ovf      <= 1'b0;
            misaddr_cnt <= '0;
        end else begin
            if (rx_wr) rx_wr_ptr <= rx_wr_ptr + ptr_one;
            if (rx_rd) rx_rd_ptr <= rx_rd_ptr + ptr_one;
            case ({rx_wr, rx_rd})
                2'b10:   rx_cnt <= rx_cnt + cnt_one;
                2'b01:   rx_cnt <= rx_cnt - cnt_one;
                default: rx_cnt <= rx_cnt;
            endcase
            if (push && addr_hit && rx_full && !rx_pop) rx_ovf <= 1'b1;
            if (push && !addr_hit && misaddr_cnt != 8'hFF)
                misaddr_cnt <= misaddr_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_bus_dev_fifo.sv
// Directed self-checking bench for bus_dev_fifo (depth 8, id 2, broadcast FF).
module tb_bus_dev_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        full;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop;
    logic        push;
    logic [15:0] D_push;
    logic        rx_pop;
    logic        rx_empty;
    logic [15:0] rx_data;
    logic        rx_ovf;
    logic        pop_err;
    logic [7:0]  misaddr_cnt;

    int errors = 0;
    int checks = 0;

    bus_dev_fifo #(.pckg_sz(16), .depth(8), .broadcast(8'hFF), .id(8'd2)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push),
        .rx_pop(rx_pop), .rx_empty(rx_empty), .rx_data(rx_data),
        .rx_ovf(rx_ovf), .pop_err(pop_err), .misaddr_cnt(misaddr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " pndng"},    32'(pndng),       32'd0);
        check({tag, " full"},     32'(full),        32'd0);
        check({tag, " D_pop"},    32'(D_pop),       32'd0);
        check({tag, " rx_empty"}, 32'(rx_empty),    32'd1);
        check({tag, " rx_data"},  32'(rx_data),     32'd0);
        check({tag, " rx_ovf"},   32'(rx_ovf),      32'd0);
        check({tag, " pop_err"},  32'(pop_err),     32'd0);
        check({tag, " misaddr"},  32'(misaddr_cnt), 32'd0);
    endtask

    logic [15:0] first3 [3] = '{16'h0111, 16'h0222, 16'h0333};
    logic [15:0] rx_in  [3] = '{16'h02AB, 16'hFFCD, 16'h03EF};

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; pop = 1'b0;
        push = 1'b0; D_push = '0; rx_pop = 1'b0;
        #2;
        check_reset_state("por");
        cyc(); cyc();
        reset = 1'b0;

        // Three writes, then three pops
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = first3[i]; cyc();
        end
        wr_en = 1'b0;
        check("t1 pndng", 32'(pndng), 32'd1);
        check("t1 head",  32'(D_pop), 32'h0111);
        pop = 1'b1;
        cyc(); check("t1 pop1", 32'(D_pop), 32'h0222);
        cyc(); check("t1 pop2", 32'(D_pop), 32'h0333);
        cyc(); pop = 1'b0;
        check("t1 empty D_pop", 32'(D_pop),   32'd0);
        check("t1 empty pndng", 32'(pndng),   32'd0);
        check("t1 no pop_err",  32'(pop_err), 32'd0);

        // Nine writes into depth 8, then drain across the pointer wrap
        for (int i = 1; i <= 9; i++) begin
            wr_en = 1'b1; wr_data = 16'h1000 + 16'(i); cyc();
            if (i == 7) check("t2 not full at 7", 32'(full), 32'd0);
            if (i == 8) check("t2 full at 8",     32'(full), 32'd1);
        end
        wr_en = 1'b0;
        check("t2 still full", 32'(full), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("t2 order %0d", i), 32'(D_pop), 32'h1000 + 32'(i));
            pop = 1'b1; cyc(); pop = 1'b0;
        end
        check("t2 drained", 32'(pndng), 32'd0);

        // Write and pop together while full: pop wins, write rejected
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; wr_data = 16'h2000 + 16'(i); cyc();
        end
        check("t3 full", 32'(full), 32'd1);
        wr_en = 1'b1; wr_data = 16'h2099; pop = 1'b1; cyc();
        wr_en = 1'b0; pop = 1'b0;
        check("t3 count 7", 32'(full),  32'd0);
        check("t3 head",    32'(D_pop), 32'h2002);
        for (int i = 2; i <= 8; i++) begin
            check($sformatf("t3 order %0d", i), 32'(D_pop), 32'h2000 + 32'(i));
            pop = 1'b1; cyc(); pop = 1'b0;
        end
        check("t3 rejected write", 32'(pndng), 32'd0);

        // Write and pop together while not full and not empty
        wr_en = 1'b1; wr_data = 16'h2A01; cyc();
        wr_data = 16'h2A02; pop = 1'b1; cyc();
        wr_en = 1'b0; pop = 1'b0;
        check("t3 mid head", 32'(D_pop), 32'h2A02);
        pop = 1'b1; cyc(); pop = 1'b0;
        check("t3 mid count", 32'(pndng), 32'd0);

        // Pop while empty sets sticky pop_err
        check("t3 pop_err clear", 32'(pop_err), 32'd0);
        pop = 1'b1; cyc(); pop = 1'b0;
        check("t3 pop_err set", 32'(pop_err), 32'd1);
        check("t3 pop empty no state", 32'(pndng), 32'd0);
        cyc(); cyc();
        check("t3 pop_err sticky", 32'(pop_err), 32'd1);

        // Write and pop together while empty: write lands
        wr_en = 1'b1; wr_data = 16'h3333; pop = 1'b1; cyc();
        wr_en = 1'b0; pop = 1'b0;
        check("t3 empty wr+pop pndng", 32'(pndng), 32'd1);
        check("t3 empty wr+pop data",  32'(D_pop), 32'h3333);
        pop = 1'b1; cyc(); pop = 1'b0;

        // RX address filter with id 2
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; D_push = rx_in[i]; cyc();
        end
        push = 1'b0;
        check("t4 misaddr", 32'(misaddr_cnt), 32'd1);
        check("t4 head",    32'(rx_data),     32'h02AB);
        rx_pop = 1'b1;
        cyc(); check("t4 second", 32'(rx_data), 32'hFFCD);
        cyc(); check("t4 empty", 32'(rx_empty), 32'd1);
        check("t4 empty data", 32'(rx_data), 32'd0);
        cyc(); rx_pop = 1'b0;
        check("t4 pop empty ignored", 32'(rx_empty), 32'd1);

        // RX overflow, then push with simultaneous read when full
        for (int i = 1; i <= 8; i++) begin
            push = 1'b1; D_push = 16'h0200 + 16'(i); cyc();
        end
        check("t5 no ovf yet", 32'(rx_ovf), 32'd0);
        D_push = 16'h0209; cyc();
        check("t5 ovf",        32'(rx_ovf),  32'd1);
        check("t5 head kept",  32'(rx_data), 32'h0201);
        D_push = 16'h020A; rx_pop = 1'b1; cyc();
        push = 1'b0; rx_pop = 1'b0;
        check("t5 head after", 32'(rx_data), 32'h0202);
        for (int i = 2; i <= 9; i++) begin
            logic [15:0] exp_rx;
            exp_rx = (i == 9) ? 16'h020A : 16'h0200 + 16'(i);
            check($sformatf("t5 order %0d", i), 32'(rx_data), 32'(exp_rx));
            rx_pop = 1'b1; cyc(); rx_pop = 1'b0;
        end
        check("t5 drained", 32'(rx_empty), 32'd1);

        // misaddr_cnt saturates at 255
        push = 1'b1; D_push = 16'h0711;
        for (int i = 0; i < 260; i++) cyc();
        push = 1'b0;
        check("t5 misaddr sat", 32'(misaddr_cnt), 32'd255);
        check("t5 misaddr no store", 32'(rx_empty), 32'd1);

        // Async reset mid-cycle with both FIFOs partly full
        wr_en = 1'b1; wr_data = 16'h4001; cyc();
        wr_data = 16'h4002; cyc();
        wr_en = 1'b0;
        push = 1'b1; D_push = 16'hFF01; cyc();
        D_push = 16'h0202; cyc();
        push = 1'b0;
        check("t6 tx loaded", 32'(D_pop),   32'h4001);
        check("t6 rx loaded", 32'(rx_data), 32'hFF01);
        check("t6 ovf held",  32'(rx_ovf),  32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async");
        cyc();
        reset = 1'b0;
        cyc();
        check_reset_state("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
